// File: rtl/sprite_dma.sv
// -----------------------------------------------------------------------------
// sprite_dma
//
// Sprite-DMA controller placed between the CPU core's bus outputs and the
// system bus. Core bus cycles pass straight through while idle. A core write
// of page number V to P_TRIGGER_ADDR stalls the core (via its ready input) and
// copies the 256 bytes at $VV00..$VVFF to P_DEST_ADDR using alternating
// read/write bus cycles.
//
// Configuration macro:
//   SPRITE_DMA_ALIGN_EN - when defined, an extra dummy cycle (ALIGN) is
//                         inserted when needed so that every DMA read falls
//                         on a get cycle and every DMA write on a put cycle.
//                         When undefined, a transfer always takes 513 cycles.
//
// Parameters:
//   P_TRIGGER_ADDR - CPU write address that starts a transfer (default $4014)
//   P_DEST_ADDR    - destination address of every DMA write  (default $2004)
//
// Ports:
//   I_clock        in  1  system clock
//   I_reset        in  1  synchronous active-high reset
//   I_cycle_en     in  1  one-clock pulse ending each CPU bus cycle
//   I_cpu_addr     in 16  core bus address
//   I_cpu_wr_data  in  8  core write data
//   I_cpu_rdwr     in  1  core bus direction (1 = read)
//   I_rd_data      in  8  system bus read data
//   O_addr         out 16 system bus address
//   O_wr_data      out 8  system bus write data
//   O_rdwr         out 1  system bus direction (1 = read)
//   O_cpu_ready    out 1  core ready input (0 = core stalled), registered
//   O_busy         out 1  high while a transfer is in progress
// -----------------------------------------------------------------------------
module sprite_dma #(
  parameter logic [15:0] P_TRIGGER_ADDR = 16'h4014,
  parameter logic [15:0] P_DEST_ADDR    = 16'h2004
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_cycle_en,
  input  logic [15:0] I_cpu_addr,
  input  logic [7:0]  I_cpu_wr_data,
  input  logic        I_cpu_rdwr,
  input  logic [7:0]  I_rd_data,
  output logic [15:0] O_addr,
  output logic [7:0]  O_wr_data,
  output logic        O_rdwr,
  output logic        O_cpu_ready,
  output logic        O_busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HALT  = 3'd1;
`ifdef SPRITE_DMA_ALIGN_EN
  localparam logic [2:0] S_ALIGN = 3'd2;
`endif
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  logic [2:0] state_reg, state_next;
  logic [7:0] page_reg,  page_next;
  logic [7:0] idx_reg,   idx_next;
  logic [7:0] data_reg,  data_next;
  logic       cpu_ready_reg;

  // A trigger is a core write to the trigger address; only honoured in IDLE.
  logic trigger;
  assign trigger = (I_cpu_rdwr == 1'b0) && (I_cpu_addr == P_TRIGGER_ADDR);

`ifdef SPRITE_DMA_ALIGN_EN
  // Get/put parity: 0 = get cycle, 1 = put cycle. Flips on every bus cycle.
  logic put_reg;

  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      put_reg <= 1'b0;
    end else if (I_cycle_en) begin
      put_reg <= ~put_reg;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    page_next  = page_reg;
    idx_next   = idx_reg;
    data_next  = data_reg;
    case (state_reg)
      S_IDLE: begin
        if (trigger) begin
          page_next  = I_cpu_wr_data;
          idx_next   = 8'd0;
          state_next = S_HALT;
        end
      end
      S_HALT: begin
`ifdef SPRITE_DMA_ALIGN_EN
        // HALT on a get cycle means the next cycle is a put cycle, which
        // would misplace the first READ; burn one more cycle in that case.
        state_next = put_reg ? S_READ : S_ALIGN;
`else
        state_next = S_READ;
`endif
      end
`ifdef SPRITE_DMA_ALIGN_EN
      S_ALIGN: begin
        state_next = S_READ;
      end
`endif
      S_READ: begin
        data_next  = I_rd_data;
        state_next = S_WRITE;
      end
      S_WRITE: begin
        // idx never carries into the page byte: $VVFF is the last source.
        if (idx_reg == 8'hFF) begin
          state_next = S_IDLE;
        end else begin
          idx_next   = idx_reg + 8'd1;
          state_next = S_READ;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers; everything advances only on bus-cycle boundaries
  // ---------------------------------------------------------------------------
  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      state_reg     <= S_IDLE;
      page_reg      <= 8'd0;
      idx_reg       <= 8'd0;
      data_reg      <= 8'd0;
      cpu_ready_reg <= 1'b1;
    end else if (I_cycle_en) begin
      state_reg     <= state_next;
      page_reg      <= page_next;
      idx_reg       <= idx_next;
      data_reg      <= data_next;
      // Ready is registered so the stall takes effect on the clock after the
      // triggering cycle ends and releases after the last WRITE ends.
      cpu_ready_reg <= (state_next == S_IDLE);
    end
  end

  // ---------------------------------------------------------------------------
  // Bus output mux
  // ---------------------------------------------------------------------------
  always_comb begin
    O_addr    = I_cpu_addr;
    O_wr_data = I_cpu_wr_data;
    O_rdwr    = I_cpu_rdwr;
    case (state_reg)
      S_IDLE: begin
        O_addr    = I_cpu_addr;
        O_wr_data = I_cpu_wr_data;
        O_rdwr    = I_cpu_rdwr;
      end
      S_READ: begin
        O_addr = {page_reg, idx_reg};
        O_rdwr = 1'b1;
      end
      S_WRITE: begin
        O_addr    = P_DEST_ADDR;
        O_wr_data = data_reg;
        O_rdwr    = 1'b0;
      end
      default: begin
        // HALT / ALIGN: dummy read of whatever the stalled core presents.
        O_addr = I_cpu_addr;
        O_rdwr = 1'b1;
      end
    endcase
  end

  assign O_cpu_ready = cpu_ready_reg;
  assign O_busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_sprite_dma.sv
module tb_sprite_dma;

`ifdef SPRITE_DMA_ALIGN_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  localparam logic [15:0] TRIG = 16'h4014;
  localparam logic [15:0] DEST = 16'h2004;

  logic        clk = 1'b0;
  logic        rst;
  logic        cycle_en;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wd;
  logic        cpu_rdwr;
  logic [7:0]  rd_data;
  logic [15:0] o_addr;
  logic [7:0]  o_wd;
  logic        o_rdwr;
  logic        o_ready;
  logic        o_busy;

  always #5 clk = ~clk;

  sprite_dma dut (
    .I_clock       (clk),
    .I_reset       (rst),
    .I_cycle_en    (cycle_en),
    .I_cpu_addr    (cpu_addr),
    .I_cpu_wr_data (cpu_wd),
    .I_cpu_rdwr    (cpu_rdwr),
    .I_rd_data     (rd_data),
    .O_addr        (o_addr),
    .O_wr_data     (o_wd),
    .O_rdwr        (o_rdwr),
    .O_cpu_ready   (o_ready),
    .O_busy        (o_busy)
  );

  // Simple memory model answering the system bus.
  logic [7:0] mem [0:65535];
  assign rd_data = mem[o_addr];

  int checks    = 0;
  int errors    = 0;
  int cyc_count = 0;   // bus cycles since reset; parity gives get(0)/put(1)

  logic [15:0] s_addr;
  logic [7:0]  s_wd;
  logic        s_rdwr, s_ready, s_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One CPU bus cycle after 0..2 idle clocks; outputs sampled mid-cycle.
  task automatic pulse(input logic [15:0] a, input logic [7:0] d, input logic rw);
    int g;
    cpu_addr = a; cpu_wd = d; cpu_rdwr = rw; cycle_en = 1'b0;
    g = $urandom_range(0, 2);
    repeat (g) begin @(posedge clk); @(negedge clk); end
    cycle_en = 1'b1;
    #1;
    s_addr = o_addr; s_wd = o_wd; s_rdwr = o_rdwr; s_ready = o_ready; s_busy = o_busy;
    @(posedge clk); @(negedge clk);
    cycle_en = 1'b0;
    cyc_count++;
    $display("cyc %0d addr=%h wd=%h rdwr=%0b ready=%0b busy=%0b", cyc_count, s_addr, s_wd, s_rdwr, s_ready, s_busy);
  endtask

  task automatic do_reset(input logic with_en);
    rst = 1'b1; cycle_en = with_en;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; cycle_en = 1'b0;
    cyc_count = 0;
  endtask

  // halt_put: 1 = HALT on put cycle, 0 = on get cycle, -1 = don't care.
  // abort_n > 0: reset after that many DMA writes.
  task automatic do_transfer(input logic [7:0] page, input int abort_n, input int halt_put);
    int pre, len, writes, low_cnt, guard, j, i;
    logic [15:0] a, src;
    logic [7:0]  d;
    logic        rw;
    if (halt_put >= 0 && ((cyc_count + 1) % 2) != halt_put) pulse(16'h8000, 8'h00, 1'b1);
    pulse(TRIG, page, 1'b0);
    chk("trig_ready", s_ready, 1'b1);
    chk("trig_busy", s_busy, 1'b0);
    chk("trig_addr", s_addr, TRIG);
    chk("trig_rdwr", s_rdwr, 1'b0);
    chk("trig_wd", s_wd, page);
    pre = (ALIGN && (cyc_count % 2) == 0) ? 2 : 1;
    len = pre + 512;
    writes = 0; low_cnt = 0;
    for (int k = 1; k <= len + 1; k++) begin
      if (k <= len) begin
        a = 16'($urandom); d = 8'($urandom); rw = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) == 0) begin a = TRIG; rw = 1'b0; end
      end else begin
        a = 16'h8000; d = 8'h00; rw = 1'b1;
      end
      pulse(a, d, rw);
      if (!s_ready) low_cnt++;
      if (k <= len) begin
        chk("stall_ready", s_ready, 1'b0);
        chk("stall_busy", s_busy, 1'b1);
        if (k <= pre) begin
          chk("dummy_addr", s_addr, a);
          chk("dummy_rdwr", s_rdwr, 1'b1);
        end else begin
          j = k - pre - 1;
          i = j / 2;
          src = {page, 8'(i)};
          if (j % 2 == 0) begin
            chk("read_addr", s_addr, src);
            chk("read_rdwr", s_rdwr, 1'b1);
          end else begin
            chk("write_addr", s_addr, DEST);
            chk("write_rdwr", s_rdwr, 1'b0);
            chk("write_data", s_wd, mem[src]);
            writes++;
            if (abort_n > 0 && writes == abort_n) break;
          end
        end
      end else begin
        chk("end_ready", s_ready, 1'b1);
        chk("end_busy", s_busy, 1'b0);
        chk("end_addr", s_addr, 16'h8000);
        chk("end_rdwr", s_rdwr, 1'b1);
      end
    end
    if (abort_n > 0) begin
      do_reset(1'b1);
      #1;
      chk("abort_ready", o_ready, 1'b1);
      chk("abort_busy", o_busy, 1'b0);
      for (int n = 0; n < 10; n++) begin
        a = 16'($urandom);
        pulse(a, 8'h00, 1'b1);
        chk("abort_passthru", s_addr, a);
        chk("abort_no_dest_wr", (s_rdwr == 1'b0 && s_addr == DEST), 1'b0);
        chk("abort_idle_ready", s_ready, 1'b1);
      end
    end else begin
      guard = 0;
      while (!s_ready && guard < 50) begin
        pulse(16'h8000, 8'h00, 1'b1);
        if (!s_ready) low_cnt++;
        guard++;
      end
      chk("stall_len", low_cnt, len);
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  wd;
    logic        rw;
    logic [15:0] exp_addr;
    logic        exp_rdwr;
    logic        exp_ready;
    logic        exp_busy;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{16'h8000, 8'h00, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{16'h4015, 8'h02, 1'b0, 16'h4015, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{16'h4014, 8'h00, 1'b1, 16'h4014, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{16'h4013, 8'h07, 1'b0, 16'h4013, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'h2004, 8'h3C, 1'b0, 16'h2004, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{16'h0123, 8'h00, 1'b1, 16'h0123, 1'b1, 1'b1, 1'b0};

    for (int n = 0; n < 65536; n++) mem[n] = 8'($urandom);
    mem[16'h8000] = 8'h5A;
    for (int n = 0; n < 256; n++) mem[16'h0200 + n] = 8'(n) ^ 8'hA5;

    rst = 1'b1; cycle_en = 1'b0; cpu_addr = 16'h1234; cpu_wd = 8'h99; cpu_rdwr = 1'b0;
    @(negedge clk);
    do_reset(1'b0);
    #1;
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_addr", o_addr, 16'h1234);
    chk("rst_wd", o_wd, 8'h99);
    chk("rst_rdwr", o_rdwr, 1'b0);

    // Pass-through and non-trigger accesses.
    for (int n = 0; n < 6; n++) begin
      pulse(vecs[n].addr, vecs[n].wd, vecs[n].rw);
      chk("vec_addr", s_addr, vecs[n].exp_addr);
      chk("vec_rdwr", s_rdwr, vecs[n].exp_rdwr);
      chk("vec_wd", s_wd, vecs[n].wd);
      chk("vec_ready", s_ready, vecs[n].exp_ready);
      chk("vec_busy", s_busy, vecs[n].exp_busy);
    end

    // Basic transfer, HALT on put then on get.
    do_transfer(8'h02, 0, 1);
    do_transfer(8'h02, 0, 0);
    // Random pages and alignment.
    do_transfer(8'($urandom), 0, -1);
    do_transfer(8'($urandom), 0, -1);
    // Wrap boundary.
    do_transfer(8'hFF, 0, -1);
    // Reset after 100 writes, then restart from idx 0.
    do_transfer(8'h33, 100, -1);
    do_transfer(8'h33, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_dma.md
# sprite_dma

Sprite-DMA controller that sits directly downstream of the CPU core's bus outputs and upstream of the system bus. It passes core bus cycles through transparently. When the core writes page number `V` to `$4014`, it stalls the core through the core's ready input. It then copies 256 bytes from `$VV00..$VVFF` to `$2004` using alternating read/write bus cycles, with 2A03-style get/put alignment.

## Interface
Parameters:
- `P_TRIGGER_ADDR`, default `16'h4014`: CPU write address that starts a transfer.
- `P_DEST_ADDR`, default `16'h2004`: destination address of every DMA write.

Ports:
- `I_clock` in 1: system clock. One clock; everything is synchronous to it.
- `I_reset` in 1: reset, synchronous and active-high (asserted = 1).
- `I_cycle_en` in 1: one-clock pulse marking the end of each CPU bus cycle. It is free-running and does not stop while the core is stalled.
- `I_cpu_addr` in 16: core bus address.
- `I_cpu_wr_data` in 8: core write data.
- `I_cpu_rdwr` in 1: core bus direction, 1 = read, 0 = write.
- `I_rd_data` in 8: system bus read data.
- `O_addr` out 16: system bus address.
- `O_wr_data` out 8: system bus write data.
- `O_rdwr` out 1: system bus direction, 1 = read.
- `O_cpu_ready` out 1: connects to the core's ready input; 0 = core stalled.
- `O_busy` out 1: high while a transfer is in progress.

## Operation
- **States:** IDLE, HALT, ALIGN, READ, WRITE. All state, counters and latches are registered and advance only on clocks where `I_cycle_en` = 1, except reset.
- **Parity bit `put`:** toggles on every `I_cycle_en`; reset value 0. `put` = 0 is a get cycle, 1 is a put cycle.
- **IDLE:**
  - Bus passes through combinationally: `O_addr` = `I_cpu_addr`, `O_wr_data` = `I_cpu_wr_data`, `O_rdwr` = `I_cpu_rdwr`.
  - `O_cpu_ready` = 1, `O_busy` = 0.
  - On `I_cycle_en` with `I_cpu_rdwr` = 0 and `I_cpu_addr` = `P_TRIGGER_ADDR`: latch `page` ← `I_cpu_wr_data`, `idx` ← 0, go to HALT. The triggering write itself completes on the bus normally.
- **HALT:** one dummy cycle.
  - `O_cpu_ready` = 0, `O_busy` = 1.
  - Bus drives a read of `I_cpu_addr`, `O_rdwr` = 1.
  - Next state: ALIGN if the following cycle is a put cycle and `SPRITE_DMA_ALIGN_EN` is defined; otherwise READ.
- **ALIGN:** one dummy read of `I_cpu_addr`, then READ.
- **READ:**
  - `O_addr` = {`page`, `idx`}, `O_rdwr` = 1.
  - On `I_cycle_en`: `data` ← `I_rd_data`; go to WRITE.
- **WRITE:**
  - `O_addr` = `P_DEST_ADDR`, `O_wr_data` = `data`, `O_rdwr` = 0.
  - On `I_cycle_en`: if `idx` = 8'hFF, go to IDLE; else `idx` ← `idx` + 1 and go to READ.
- **Address width:** `idx` is 8 bits. The address never carries into the page byte; `$VVFF` is the last source.
- **Output outside IDLE:** `O_cpu_ready` = 0 in every non-IDLE state. It is a registered output, equal to (next state == IDLE).
- **Trigger writes while busy:** cannot occur, because the core is stalled. If one is presented anyway, it is ignored.
- **Reset mid-transfer:** go to IDLE, `O_cpu_ready` = 1, `put` = 0, `idx` = 0, `page` = 0, `data` = 0. The transfer is abandoned with no further bus writes.
- **Reset values:** `O_cpu_ready` = 1 and `O_busy` = 0. `O_addr`, `O_wr_data` and `O_rdwr` follow the core inputs (pass-through).

## Timing
- `O_cpu_ready` falls on the clock after the `I_cycle_en` that ends the trigger write. It rises on the clock after the `I_cycle_en` that ends the last WRITE.
- **Stall length:** 1 HALT + 0 or 1 ALIGN + 512 = 513 or 514 CPU cycles.
- **Alignment:** every READ lands on a get cycle and every WRITE on a put cycle when `SPRITE_DMA_ALIGN_EN` is defined.
- **Data latency:** source byte `i` is captured at the end of its READ cycle and driven during the immediately following WRITE cycle.
- **Cycle enable:** `I_cycle_en` asserted on consecutive clocks is legal. Each pulse is exactly one bus cycle.

## Configuration
- **`SPRITE_DMA_ALIGN_EN` defined:** ALIGN state present; a transfer takes 513 cycles if HALT falls on a put cycle, 514 if it falls on a get cycle.
- **`SPRITE_DMA_ALIGN_EN` undefined:** ALIGN state and the `put` dependency are removed. Every transfer takes exactly 513 cycles and reads may land on put cycles.

## Test plan
- **Pass-through:** idle, core reads `$8000` with `I_rd_data` = 8'h5A -> `O_addr` = 16'h8000, `O_rdwr` = 1, `O_cpu_ready` = 1, `O_busy` = 0.
- **Basic transfer:** core writes 8'h02 to `$4014`, memory `$0200+i` = `i` XOR 8'hA5 -> 256 writes to `$2004` with data `i` XOR 8'hA5, in order `i` = 0..255.
- **Stall length:** with `SPRITE_DMA_ALIGN_EN`, trigger so HALT falls on a put cycle -> `O_cpu_ready` low for exactly 513 `I_cycle_en` pulses. Trigger so HALT falls on a get cycle -> exactly 514 pulses. Without the macro -> 513 in both cases.
- **Wrap boundary:** page 8'hFF -> last source address `$FFFF`; no access to `$0000`; `idx` ends the transfer at 8'hFF.
- **Reset mid-transfer:** assert `I_reset` after 100 writes -> next clock `O_cpu_ready` = 1 and `O_busy` = 0, no further `$2004` writes. A subsequent trigger restarts from `idx` 0.
- **Non-trigger writes:** core writes to `$4015` and reads `$4014` -> no transfer starts, `O_cpu_ready` stays 1.
